i2s_tdm_xmit: RTL

I2S_TDM_XMIT -- requirements
Module: i2s_tdm_xmit

---
 rtl/i2s_tdm_xmit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/i2s_tdm_xmit.sv
// Double-buffered I2S / left-justified / TDM serial transmitter.
// Serial data changes only on BCLK falling-edge strobes; lrclk edges mark frames.
module i2s_tdm_xmit #(
   parameter int DATA_BITS = 16,
   parameter int CHANNELS  = 2,
   parameter int MODE      = 0,
   parameter int LRPOL     = 0,
   parameter int TPD       = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          lrclk,
   input  logic                          CBrise,
   input  logic                          CBfall,
   input  logic [CHANNELS*DATA_BITS-1:0] sample,
   input  logic                          xmit_ack,
   output logic                          outbit,
   output logic                          xmit_rdy,
   output logic                          underrun,
   output logic                          frame_err
);

   localparam int unsigned NT = CHANNELS * DATA_BITS;
   localparam int unsigned CW = $clog2(NT + 1);
   localparam int unused_tpd = TPD;

   typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_e;

   state_e          state_q, state_d;
   logic            lrclk_q;
   logic [NT-1:0]   hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [NT-1:0]   shift_q, shift_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            outbit_q, outbit_d;
   logic            xmit_rdy_q, xmit_rdy_d;
   logic            underrun_q, underrun_d;
   logic            frame_err_q, frame_err_d;
   logic            frame_start_c;
   logic            accept_c;
   logic [NT-1:0]   frame_c;
   logic            unused_cbrise;

   assign unused_cbrise = CBrise;

   assign frame_start_c = (LRPOL == 0) ? (lrclk_q & ~lrclk) : (~lrclk_q & lrclk);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a frame edge restarts the sequence from any state
   always_comb begin
      state_d = state_q;
      if (frame_start_c) begin
         if (MODE == 0) state_d = CBfall ? SHIFT : DELAY;
         else           state_d = SHIFT;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            DELAY:   if (CBfall) state_d = SHIFT;
            SHIFT:   if (CBfall && (cnt_q == CW'(1))) state_d = PAD;
            PAD:     state_d = PAD;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      outbit_d    = outbit_q;
      underrun_d  = 1'b0;
      frame_err_d = 1'b0;
      accept_c    = xmit_ack & xmit_rdy_q;

      if (hold_full_q)   frame_c = hold_q;
      else if (accept_c) frame_c = sample;
      else               frame_c = '0;

      if (frame_start_c) begin
         hold_full_d = 1'b0;
         underrun_d  = ~hold_full_q & ~accept_c;
         frame_err_d = (state_q == DELAY) || ((state_q == SHIFT) && (cnt_q != '0));
         // Left-justified: a coincident falling strobe already emits the MSB
         if ((MODE != 0) && CBfall) begin
            outbit_d = frame_c[NT-1];
            shift_d  = {frame_c[NT-2:0], 1'b0};
            cnt_d    = CW'(NT - 1);
         end else begin
            shift_d  = frame_c;
            cnt_d    = CW'(NT);
         end
      end else begin
         if (accept_c) begin
            hold_d      = sample;
            hold_full_d = 1'b1;
         end
         case (state_q)
            IDLE:  outbit_d = 1'b0;
            SHIFT: if (CBfall && (cnt_q != '0)) begin
                      outbit_d = shift_q[NT-1];
                      shift_d  = {shift_q[NT-2:0], 1'b0};
                      cnt_d    = cnt_q - CW'(1);
                   end
            PAD:   if (CBfall) outbit_d = 1'b0;
            default: ;
         endcase
      end
      xmit_rdy_d = ~hold_full_d;
   end

   // Datapath registers; lrclk is tracked through reset to avoid a false edge
   always_ff @(posedge clk) begin
      if (rst) begin
         lrclk_q     <= lrclk;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         outbit_q    <= 1'b0;
         xmit_rdy_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         lrclk_q     <= lrclk;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         outbit_q    <= outbit_d;
         xmit_rdy_q  <= xmit_rdy_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign outbit    = outbit_q;
   assign xmit_rdy  = xmit_rdy_q;
   assign underrun  = underrun_q;
   assign frame_err = frame_err_q;

endmodule
